// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage; owns the PC, drives the synchronous
//            instruction memory and hands words to decode via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_insn,
    output logic [31:0] id_pc,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [31:0] squash_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic [31:0] r_squash_count;
    logic        r_misalign_err;
    logic [31:0] w_next_pc;
    logic        w_live;
    logic        w_fire;

    // The memory has no enable, so stalling means re-presenting the current PC.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (redirect_valid) begin
            w_next_pc = {redirect_pc[31:2], 2'b00};
        end else if (r_state == BOOT) begin
            w_next_pc = r_pc;
        end else if (!id_ready) begin
            w_next_pc = r_pc;
        end
    end

    assign w_live       = (r_state != BOOT);
    assign id_valid     = w_live && !redirect_valid;
    assign w_fire       = id_valid && id_ready;
    assign imem_addr    = w_next_pc;
    assign id_insn      = imem_rd_data;
    assign id_pc        = r_pc;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;
    assign squash_count = r_squash_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC;
            r_fetch_count  <= 32'd0;
            r_squash_count <= 32'd0;
            r_misalign_err <= 1'b0;
        end else begin
            r_pc           <= w_next_pc;
            r_misalign_err <= redirect_valid && (|redirect_pc[1:0]);
            if (redirect_valid || (r_state == BOOT)) begin
                r_state <= RUN;
            end else if (!id_ready) begin
                r_state <= STALL;
            end else begin
                r_state <= RUN;
            end
            if (w_fire) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_live && redirect_valid) begin
                r_squash_count <= r_squash_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire
